// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Memory handshake between the multi-cycle controller and the memory system.
//   mem_req   : access request, held for as long as the access is pending
//   mem_we    : write qualifier for mem_req (1 = store)
//   mem_ready : access complete; read data is valid in this cycle
// The master modport is the controller side and the slave modport is the
// memory side.
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control unit.  Each instruction is sequenced through
// FETCH -> DECODE -> EXEC -> MEM -> WB.  Not every instruction visits every
// state.  The unit keeps the Z/N status flags, resolves the extended
// branch/jump set (bz, brz, bmn, jmor, jalm, jspal) and guards every memory
// wait with a configurable timeout.
//
// Parameters
//   MEM_TIMEOUT : maximum wait cycles per memory access (0 = no timeout)
//   TMO_W       : timeout counter width, 2**TMO_W > MEM_TIMEOUT
//   CNT_W       : retired-instruction counter width
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   mem               : memory handshake (mem_req / mem_we / mem_ready)
//   opcode, funct     : instruction fields, valid from DECODE onward
//   alu_zero, alu_neg : ALU status of the current result
//   ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
//   alu_src, alu_op   : datapath strobes and mux selects
//   flag_z, flag_n    : status flag register
//   state             : 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
//   timeout_err       : sticky memory timeout indication
//   instr_count       : retired instructions
//
// Optional feature
//   MULTICYCLE_PERF_CNT_EN : when defined, instr_count counts retired
//   instructions (modulo 2**CNT_W).  Otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   mem,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic [2:0]             pc_src,
    output logic                   reg_write,
    output logic [1:0]             reg_dst,
    output logic [1:0]             mem_to_reg,
    output logic                   alu_src,
    output logic [1:0]             alu_op,
    output logic                   flag_z,
    output logic                   flag_n,
    output logic [2:0]             state,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RTYPE, C_LW, C_SW, C_BEQ, C_BZ, C_BRZ,
        C_BMN, C_JMOR, C_JALM, C_JSPAL
    } class_t;

    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           cur_state;
    state_t           nxt_state;
    class_t           cls;
    class_t           dec_cls;
    logic [TMO_W-1:0] tmo_cnt;
    logic             req;
    logic             we;
    logic             waiting;
    logic             tmo_hit;
    logic             upd_flags;

    assign state       = cur_state;
    assign mem.mem_req = req;
    assign mem.mem_we  = we;

    // Classify the instruction.  brz and jmor share opcode 0 with the
    // R-type group and are told apart by funct.
    always_comb begin
        dec_cls = C_NOP;
        case (opcode)
            6'd0: begin
                if (funct == 6'd20)
                    dec_cls = C_BRZ;
                else if (funct == 6'd37)
                    dec_cls = C_JMOR;
                else
                    dec_cls = C_RTYPE;
            end
            6'd35:   dec_cls = C_LW;
            6'd43:   dec_cls = C_SW;
            6'd4:    dec_cls = C_BEQ;
            6'd21:   dec_cls = C_BMN;
            6'd24:   dec_cls = C_BZ;
            6'd19:   dec_cls = C_JALM;
            6'd23:   dec_cls = C_JSPAL;
            default: dec_cls = C_NOP;
        endcase
    end

    // The limit is hit on the last permitted waiting cycle.  A mem_ready in
    // that same cycle is not a wait, so the access completes normally.
    assign waiting = req && !mem.mem_ready;
    assign tmo_hit = (MEM_TIMEOUT > 0) && waiting && (tmo_cnt == TMO_LAST);

    // Next state and all strobes.  Everything is held at zero while reset
    // is asserted, so no request or write can escape mid-reset.
    always_comb begin
        nxt_state  = cur_state;
        req        = 1'b0;
        we         = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 3'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        upd_flags  = 1'b0;
        if (rst_n) begin
            case (cur_state)
                S_FETCH: begin
                    req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        nxt_state = S_DECODE;
                    end
                end
                S_DECODE: nxt_state = S_EXEC;
                S_EXEC: begin
                    nxt_state = S_FETCH;
                    case (cls)
                        C_RTYPE: begin
                            alu_op    = 2'b10;
                            nxt_state = S_WB;
                        end
                        C_LW, C_SW, C_JMOR, C_JALM: begin
                            alu_src   = 1'b1;
                            nxt_state = S_MEM;
                        end
                        C_BEQ: begin
                            alu_op = 2'b01;
                            if (alu_zero) begin
                                pc_write = 1'b1;
                                pc_src   = 3'd1;
                            end
                        end
                        C_BZ: begin
                            if (flag_z) begin
                                pc_write = 1'b1;
                                pc_src   = 3'd1;
                            end
                        end
                        C_BRZ: begin
                            if (flag_z) begin
                                pc_write = 1'b1;
                                pc_src   = 3'd2;
                            end
                        end
                        C_BMN: begin
                            alu_src = 1'b1;
                            if (flag_n)
                                nxt_state = S_MEM;
                        end
                        C_JSPAL: begin
                            reg_write  = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                            pc_write   = 1'b1;
                            pc_src     = 3'd4;
                        end
                        default: nxt_state = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    req = 1'b1;
                    we  = (cls == C_SW);
                    if (mem.mem_ready) begin
                        nxt_state = S_FETCH;
                        case (cls)
                            C_LW: nxt_state = S_WB;
                            C_BMN, C_JMOR: begin
                                pc_write = 1'b1;
                                pc_src   = 3'd3;
                            end
                            C_JALM: begin
                                pc_write   = 1'b1;
                                pc_src     = 3'd3;
                                reg_write  = 1'b1;
                                reg_dst    = 2'd2;
                                mem_to_reg = 2'd2;
                            end
                            default: nxt_state = S_FETCH;
                        endcase
                    end
                end
                S_WB: begin
                    nxt_state = S_FETCH;
                    if (cls == C_RTYPE) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'd1;
                        upd_flags = 1'b1;
                    end else if (cls == C_LW) begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'd1;
                    end
                end
                default: nxt_state = S_FETCH;
            endcase
            // A timeout abandons the access; an abort from FETCH simply
            // re-issues the same fetch.
            if (tmo_hit)
                nxt_state = S_FETCH;
        end
    end

    // State register and the class latched during DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            cls       <= C_NOP;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE)
                cls <= dec_cls;
        end
    end

    // Status flags, written only by an R-type write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (upd_flags) begin
            flag_z <= alu_zero;
            flag_n <= alu_neg;
        end
    end

    // Wait counter restarts whenever a new access begins (state change or
    // abort) and counts cycles spent waiting on mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (tmo_hit)
                timeout_err <= 1'b1;
            if ((nxt_state != cur_state) || tmo_hit)
                tmo_cnt <= '0;
            else if (waiting)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    assign retire = (nxt_state == S_FETCH) && (cur_state != S_FETCH) && !tmo_hit;

    // Retired-instruction counter; aborted accesses do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_q + 1'b1;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control (MEM_TIMEOUT = 4).  For every
// instruction the reference model expands the rules of the instruction set
// into a queue of per-cycle steps.  Each step holds the inputs to drive, the
// expected strobes, and the model-state updates that take effect at the
// following clock edge.  Inputs the controller should ignore are randomised.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int TMO   = 4;
    localparam int CNT_W = 32;

    localparam int K_NOP = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BZ = 5,
                   K_BRZ = 6, K_BMN = 7, K_JMOR = 8, K_JALM = 9, K_JSPAL = 10;

    typedef struct {
        bit          ready;
        bit          zero;
        bit          neg;
        bit          fetch;
        bit          set_err;
        bit          upd_flags;
        bit          retire;
        logic [17:0] exp;
    } step_t;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             alu_neg;
    logic             ir_write;
    logic             pc_write;
    logic [2:0]       pc_src;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             flag_z;
    logic             flag_n;
    logic [2:0]       state;
    logic             timeout_err;
    logic [CNT_W-1:0] instr_count;

    multicycle_control_if mif ();

    multicycle_control #(
        .MEM_TIMEOUT (TMO),
        .TMO_W       (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (mif),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .state       (state),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          step_no;
    bit          m_z;
    bit          m_n;
    bit          m_err;
    int unsigned m_count;
    logic [5:0]  cur_op;
    logic [5:0]  cur_fn;
    step_t       plan[$];

    function automatic logic [17:0] mk(input int st, input int req, input int we,
                                       input int irw, input int pcw, input int pcs,
                                       input int rw, input int rd, input int mtr,
                                       input int as, input int aop);
        return {3'(st), 1'(req), 1'(we), 1'(irw), 1'(pcw), 3'(pcs),
                1'(rw), 2'(rd), 2'(mtr), 1'(as), 2'(aop)};
    endfunction

    function automatic bit rnd(input int v);
        if (v < 0)
            return bit'($urandom_range(0, 1));
        return bit'(v);
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0)
            return (fn == 6'd20) ? K_BRZ : ((fn == 6'd37) ? K_JMOR : K_R);
        case (op)
            6'd35:   return K_LW;
            6'd43:   return K_SW;
            6'd4:    return K_BEQ;
            6'd21:   return K_BMN;
            6'd24:   return K_BZ;
            6'd19:   return K_JALM;
            6'd23:   return K_JSPAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int unsigned exp_count();
`ifdef MULTICYCLE_PERF_CNT_EN
        return m_count;
`else
        return 0;
`endif
    endfunction

    task automatic push(input int ready, input int zero, input int neg, input bit fetch,
                        input bit set_err, input bit upd, input bit retire,
                        input logic [17:0] e);
        step_t s;
        s.ready     = rnd(ready);
        s.zero      = rnd(zero);
        s.neg       = rnd(neg);
        s.fetch     = fetch;
        s.set_err   = set_err;
        s.upd_flags = upd;
        s.retire    = retire;
        s.exp       = e;
        plan.push_back(s);
    endtask

    // Expand one instruction into per-cycle expectations.  fw/mw are the
    // wait cycles before mem_ready in FETCH/MEM; waits of TMO or more time out.
    task automatic build_plan(input int k, input int fw, input int mw,
                              input int exz, input int wbz, input int wbn);
        int  rem;
        bit  z;
        bit  to_mem;
        int  we;
        plan.delete();
        to_mem = 1'b0;
        rem = fw;
        while (rem >= TMO) begin
            for (int i = 0; i < TMO; i++)
                push(0, -1, -1, 1, (i == TMO - 1), 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0));
            rem -= TMO;
        end
        for (int i = 0; i < rem; i++)
            push(0, -1, -1, 1, 0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0));
        push(1, -1, -1, 1, 0, 0, 0, mk(0,1,0,1,1,0,0,0,0,0,0));
        push(-1, -1, -1, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,0,0,0,0));
        case (k)
            K_R: begin
                push(-1, -1, -1, 0, 0, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,2));
                push(-1, wbz, wbn, 0, 0, 1, 1, mk(4,0,0,0,0,0,1,1,0,0,0));
            end
            K_LW, K_SW, K_JMOR, K_JALM: begin
                push(-1, -1, -1, 0, 0, 0, 0, mk(2,0,0,0,0,0,0,0,0,1,0));
                to_mem = 1'b1;
            end
            K_BEQ: begin
                z = rnd(exz);
                push(-1, int'(z), -1, 0, 0, 0, 1, mk(2,0,0,0,z,z ? 1 : 0,0,0,0,0,1));
            end
            K_BZ:
                push(-1, -1, -1, 0, 0, 0, 1, mk(2,0,0,0,m_z,m_z ? 1 : 0,0,0,0,0,0));
            K_BRZ:
                push(-1, -1, -1, 0, 0, 0, 1, mk(2,0,0,0,m_z,m_z ? 2 : 0,0,0,0,0,0));
            K_BMN: begin
                push(-1, -1, -1, 0, 0, 0, !m_n, mk(2,0,0,0,0,0,0,0,0,1,0));
                to_mem = m_n;
            end
            K_JSPAL:
                push(-1, -1, -1, 0, 0, 0, 1, mk(2,0,0,0,1,4,1,2,2,0,0));
            default:
                push(-1, -1, -1, 0, 0, 0, 1, mk(2,0,0,0,0,0,0,0,0,0,0));
        endcase
        if (to_mem) begin
            we = (k == K_SW) ? 1 : 0;
            if (mw >= TMO) begin
                for (int i = 0; i < TMO; i++)
                    push(0, -1, -1, 0, (i == TMO - 1), 0, 0, mk(3,1,we,0,0,0,0,0,0,0,0));
            end else begin
                for (int i = 0; i < mw; i++)
                    push(0, -1, -1, 0, 0, 0, 0, mk(3,1,we,0,0,0,0,0,0,0,0));
                case (k)
                    K_LW: begin
                        push(1, -1, -1, 0, 0, 0, 0, mk(3,1,0,0,0,0,0,0,0,0,0));
                        push(-1, -1, -1, 0, 0, 0, 1, mk(4,0,0,0,0,0,1,0,1,0,0));
                    end
                    K_SW:
                        push(1, -1, -1, 0, 0, 0, 1, mk(3,1,1,0,0,0,0,0,0,0,0));
                    K_JALM:
                        push(1, -1, -1, 0, 0, 0, 1, mk(3,1,0,0,1,3,1,2,2,0,0));
                    default:
                        push(1, -1, -1, 0, 0, 0, 1, mk(3,1,0,0,1,3,0,0,0,0,0));
                endcase
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1: drive the step, check at the falling edge, then
    // apply the model updates that the rising edge commits.
    task automatic applyStimulus(input step_t s);
        mif.mem_ready = s.ready;
        alu_zero      = s.zero;
        alu_neg       = s.neg;
        opcode        = s.fetch ? 6'($urandom) : cur_op;
        funct         = s.fetch ? 6'($urandom) : cur_fn;
        @(negedge clk);
        checkOutput($sformatf("outputs@%0d", step_no),
                    32'({state, mif.mem_req, mif.mem_we, ir_write, pc_write, pc_src,
                         reg_write, reg_dst, mem_to_reg, alu_src, alu_op}),
                    32'(s.exp));
        checkOutput($sformatf("flags@%0d", step_no), 32'({flag_z, flag_n}), 32'({m_z, m_n}));
        checkOutput($sformatf("timeout_err@%0d", step_no), 32'(timeout_err), 32'(m_err));
        checkOutput($sformatf("instr_count@%0d", step_no), 32'(instr_count), 32'(exp_count()));
        @(posedge clk);
        if (s.set_err)
            m_err = 1'b1;
        if (s.upd_flags) begin
            m_z = s.zero;
            m_n = s.neg;
        end
        if (s.retire)
            m_count++;
        step_no++;
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input int exz, input int wbz, input int wbn);
        cur_op = op;
        cur_fn = fn;
        build_plan(classify(op, fn), fw, mw, exz, wbz, wbn);
        foreach (plan[i])
            applyStimulus(plan[i]);
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TMO - 1))
                                          : int'($urandom_range(TMO, TMO + 2));
    endfunction

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] ops[12];
        vectors       = 0;
        miscompares   = 0;
        step_no       = 0;
        m_z           = 1'b0;
        m_n           = 1'b0;
        m_err         = 1'b0;
        m_count       = 0;
        cur_op        = 6'd0;
        cur_fn        = 6'd0;
        rst_n         = 1'b0;
        mif.mem_ready = 1'b0;
        alu_zero      = 1'b0;
        alu_neg       = 1'b0;
        opcode        = 6'd0;
        funct         = 6'd0;
        ops = '{6'd0, 6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd21, 6'd24, 6'd19, 6'd23, 6'd2, 6'd63};

        #12;
        checkOutput("reset_outputs",
                    32'({state, mif.mem_req, mif.mem_we, ir_write, pc_write, pc_src,
                         reg_write, reg_dst, mem_to_reg, alu_src, alu_op}), 32'd0);
        checkOutput("reset_flags", 32'({flag_z, flag_n}), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("reset_instr_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] R-type add with zero result");
        run_instr(6'd0, 6'd32, 0, 0, -1, 1, 0);
        #3 checkOutput("rtype_flag_z", 32'(flag_z), 32'd1);
        #1;

        $display("[TB] lw with 3 wait cycles");
        run_instr(6'd35, 6'd0, $urandom_range(0, 2), 3, -1, -1, -1);

        $display("[TB] bz taken then not taken");
        run_instr(6'd24, 6'd0, 1, 0, -1, -1, -1);
        run_instr(6'd0, 6'd33, 0, 0, -1, 0, 1);
        run_instr(6'd24, 6'd0, 0, 0, -1, -1, -1);
        run_instr(6'd21, 6'd0, 0, 1, -1, -1, -1);

        $display("[TB] jalm with 2 wait cycles, brz, jmor, jspal, beq");
        run_instr(6'd19, 6'd0, 0, 2, -1, -1, -1);
        run_instr(6'd0, 6'd20, 0, 0, -1, -1, -1);
        run_instr(6'd0, 6'd37, 2, 1, -1, -1, -1);
        run_instr(6'd23, 6'd0, 0, 0, -1, -1, -1);
        run_instr(6'd4, 6'd0, 0, 0, 1, -1, -1);
        run_instr(6'd4, 6'd0, 0, 0, 0, -1, -1);

        $display("[TB] sw timeout and fetch timeout");
        run_instr(6'd43, 6'd0, 0, TMO + 2, -1, -1, -1);
        run_instr(6'd2, 6'd0, TMO + 1, 0, -1, -1, -1);
        run_instr(6'd35, 6'd0, 0, TMO - 1, -1, -1, -1);

        $display("[TB] randomised instruction stream");
        for (int n = 0; n < 40; n++) begin
            int idx;
            idx = int'($urandom_range(0, 11));
            op  = ops[idx];
            fn  = 6'($urandom);
            if (idx == 1)
                fn = 6'd20;
            if (idx == 2)
                fn = 6'd37;
            if (idx == 11)
                op = 6'($urandom);
            run_instr(op, fn, rand_wait(), rand_wait(), -1, -1, -1);
        end

        $display("[TB] reset during lw MEM");
        run_instr(6'd0, 6'd32, 0, 0, -1, 1, 1);
        cur_op = 6'd35;
        cur_fn = 6'd0;
        build_plan(K_LW, 0, 3, -1, -1, -1);
        while (plan.size() > 4)
            void'(plan.pop_back());
        foreach (plan[i])
            applyStimulus(plan[i]);
        mif.mem_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_outputs",
                    32'({state, mif.mem_req, mif.mem_we, ir_write, pc_write, pc_src,
                         reg_write, reg_dst, mem_to_reg, alu_src, alu_op}), 32'd0);
        checkOutput("midreset_flags", 32'({flag_z, flag_n}), 32'd0);
        checkOutput("midreset_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("midreset_instr_count", 32'(instr_count), 32'd0);
        m_z     = 1'b0;
        m_n     = 1'b0;
        m_err   = 1'b0;
        m_count = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(6'd35, 6'd0, 1, 1, -1, -1, -1);
        run_instr(6'd0, 6'd34, 0, 0, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
